character_ctrl: RTL and testbench
=================================

// Module: character_ctrl
// PURPOSE
//  Parametrised player-character motion controller for the head-soccer game. It is the
//  successor of the fixed per-player blocks: one RTL body serves both players through
//  parameters for key bindings, spawn point, speeds and arena bounds.
//  Adds a jump/air state machine, terminal fall speed, ceiling bounce-stop, facing
//  direction and a timed kick pulse.
//  Sits between the USB keycode register and the sprite/collision logic; updates once
//  per frame_clk.
// PARAMETERS
//  KEY_SLOTS  4    number of 8-bit keycode slots packed in keycode
//  KEY_LEFT   8'h50  left keycode;  KEY_RIGHT 8'h4F  right keycode
//  KEY_JUMP   8'h52  jump keycode;  KEY_KICK  8'h51  kick keycode
//  SPAWN_X    440  reset X;  SPAWN_Y 240  reset Y (top-left of sprite)
//  X_MIN 0, X_MAX 639, Y_MIN 0, FLOOR_Y 400   arena bounds (pixels)
//  SIZE       32   sprite edge length (pixels)
//  WALK_SPD   4    horizontal step per frame
//  JUMP_VEL   18   launch speed (applied as -JUMP_VEL)
//  GRAVITY    1    added to Y velocity each airborne frame
//  MAX_FALL   12   maximum downward Y velocity
//  KICK_FRAMES 6   frames Kicking stays high per kick
// PORTS
//  frame_clk  in   1            frame-rate clock; all state updates on its rising edge
//  Reset      in   1            asynchronous, active-high reset
//  keycode    in   8*KEY_SLOTS  packed keycodes; slot i = keycode[8*i+7:8*i]; 8'h00 = empty
//  CharX      out  10           sprite left edge
//  CharY      out  10           sprite top edge
//  CharS      out  10           constant SIZE
//  Facing     out  1            0 = facing right, 1 = facing left
//  OnGround   out  1            1 when state is GROUND
//  Kicking    out  1            high for KICK_FRAMES frames after a kick press
// BEHAVIOUR
//  Reset (async): CharX=SPAWN_X, CharY=SPAWN_Y, VelY=0, state=AIR, Facing=0, OnGround=0,
//    Kicking=0, kick counter=0, kick_prev=0. The block falls to the floor after reset.
//  Key decode: a key is pressed if any slot equals its code; evaluation is combinational
//    and uses the current keycode value.
//  Horizontal: left only -> dx=-WALK_SPD, Facing<=1; right only -> dx=+WALK_SPD, Facing<=0;
//    both or neither -> dx=0, Facing held. Clamp nextX to [X_MIN, X_MAX-SIZE].
//  FSM GROUND/AIR:
//    GROUND: jump pressed -> VelY=-JUMP_VEL, go AIR, Y moves this same frame.
//      Otherwise Y=FLOOR_Y-SIZE and VelY=0.
//    AIR: VelY=min(VelY+GRAVITY, MAX_FALL); nextY=CharY+VelY.
//      nextY >= FLOOR_Y-SIZE -> Y=FLOOR_Y-SIZE, VelY=0, go GROUND.
//      nextY <= Y_MIN -> Y=Y_MIN, VelY=0, stay AIR.
//    Holding jump while in AIR has no effect. Re-jump requires GROUND, so jumping is
//    level-triggered from the ground.
//  Kick: rising edge of the kick key (kick_prev==0 && pressed) while counter==0 loads the
//    counter with KICK_FRAMES. Kicking = (counter!=0); the counter decrements each frame.
//    Edges seen while counting are ignored (no retrigger). Kicking is legal in either state.
//  Arithmetic: positions and velocities use 12-bit signed intermediates, clamped before
//    truncation to 10 bits; no wrap-around at any bound.
//  Outputs are registered; the effect of a key is visible on CharX/CharY one frame_clk
//    after sampling.
//  Reset mid-jump or mid-kick returns immediately to the reset values.
// STRUCTURE
//  char_pkg: typedef enum logic {GROUND, AIR} char_state_t; localparam keycode constants
//    shared by both player instances.
//  Sub-module key_match #(KEY_SLOTS, CODE): combinational slot scan -> hit. There are four
//    instances (left, right, jump, kick).
//  Everything else (FSM, velocity, clamps, kick counter) is in one always_ff plus
//    next-state always_comb.
// TESTING
//  1. Reset, no keys: after ~30 frames CharY=368, OnGround=1, CharX=440, Facing=0.
//  2. On ground, keycode=32'h0000_0050 for 10 frames -> CharX=400, Facing=1.
//     Then 8'h4F+8'h50 together -> CharX held at 400.
//  3. Grounded, jump key one frame -> next frame CharY=350 (VelY=-18), OnGround=0.
//     Apex after 18 frames; lands at 368 with OnGround=1; VelY never exceeds +12.
//  4. CharX=4, left held 3 frames -> CharX=0 and stays 0.
//     Right held at X_MAX edge -> CharX=607.
//  5. Kick pressed 1 frame -> Kicking high exactly 6 frames.
//     A second press during those 6 frames is ignored; holding the key continuously
//     gives only one pulse.
//  6. Assert Reset mid-air during a kick -> immediately CharX=440, CharY=240, Kicking=0,
//     state AIR.

Source files
------------

// File: rtl/char_pkg.sv
// rtl/char_pkg.sv - shared state type and default keycodes for the character controller
package char_pkg;

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } char_state_t;

    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_JUMP  = 8'h52;
    localparam logic [7:0] KC_KICK  = 8'h51;

endpackage

// File: rtl/key_match.sv
// rtl/key_match.sv - combinational scan of packed keycode slots for one key
module key_match #(
    parameter int         KEY_SLOTS = 4,
    parameter logic [7:0] CODE      = 8'h00
) (
    input  logic [8*KEY_SLOTS-1:0] keycode,
    output logic                   hit
);

    // Any slot holding the code counts as the key being pressed.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < KEY_SLOTS; i++) begin
            if (keycode[8*i +: 8] == CODE) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/character_ctrl.sv
// rtl/character_ctrl.sv - per-player motion controller: walk, jump/air FSM, facing, kick pulse
module character_ctrl
    import char_pkg::*;
#(
    parameter int         KEY_SLOTS   = 4,
    parameter logic [7:0] KEY_LEFT    = KC_LEFT,
    parameter logic [7:0] KEY_RIGHT   = KC_RIGHT,
    parameter logic [7:0] KEY_JUMP    = KC_JUMP,
    parameter logic [7:0] KEY_KICK    = KC_KICK,
    parameter int         SPAWN_X     = 440,
    parameter int         SPAWN_Y     = 240,
    parameter int         X_MIN       = 0,
    parameter int         X_MAX       = 639,
    parameter int         Y_MIN       = 0,
    parameter int         FLOOR_Y     = 400,
    parameter int         SIZE        = 32,
    parameter int         WALK_SPD    = 4,
    parameter int         JUMP_VEL    = 18,
    parameter int         GRAVITY     = 1,
    parameter int         MAX_FALL    = 12,
    parameter int         KICK_FRAMES = 6
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [8*KEY_SLOTS-1:0] keycode,
    output logic [9:0]             CharX,
    output logic [9:0]             CharY,
    output logic [9:0]             CharS,
    output logic                   Facing,
    output logic                   OnGround,
    output logic                   Kicking
);

    localparam logic signed [11:0] X_LO   = 12'(X_MIN);
    localparam logic signed [11:0] X_HI   = 12'(X_MAX - SIZE);
    localparam logic signed [11:0] Y_TOP  = 12'(Y_MIN);
    localparam logic signed [11:0] Y_GND  = 12'(FLOOR_Y - SIZE);
    localparam logic signed [11:0] WALK   = 12'(WALK_SPD);
    localparam logic signed [11:0] JUMPV  = 12'(JUMP_VEL);
    localparam logic signed [11:0] GRAV   = 12'(GRAVITY);
    localparam logic signed [11:0] MAXF   = 12'(MAX_FALL);
    localparam logic [9:0]         X_LO10 = 10'(X_MIN);
    localparam logic [9:0]         X_HI10 = 10'(X_MAX - SIZE);
    localparam logic [9:0]         Y_TOP10 = 10'(Y_MIN);
    localparam logic [9:0]         Y_GND10 = 10'(FLOOR_Y - SIZE);
    localparam logic [7:0]         KICK_LOAD = 8'(KICK_FRAMES);

    logic w_left, w_right, w_jump, w_kick;

    key_match #(.KEY_SLOTS(KEY_SLOTS), .CODE(KEY_LEFT))  u_left  (.keycode(keycode), .hit(w_left));
    key_match #(.KEY_SLOTS(KEY_SLOTS), .CODE(KEY_RIGHT)) u_right (.keycode(keycode), .hit(w_right));
    key_match #(.KEY_SLOTS(KEY_SLOTS), .CODE(KEY_JUMP))  u_jump  (.keycode(keycode), .hit(w_jump));
    key_match #(.KEY_SLOTS(KEY_SLOTS), .CODE(KEY_KICK))  u_kick  (.keycode(keycode), .hit(w_kick));

    char_state_t        r_state, w_state_n;
    logic [9:0]         r_x, r_y, w_x_n, w_y_n;
    logic signed [11:0] r_vel, w_vel_n;
    logic               r_facing, w_facing_n;
    logic [7:0]         r_kick_cnt, w_kick_cnt_n;
    logic               r_kick_prev;

    logic signed [11:0] w_dx, w_x_sum, w_y_sum, w_vel_up, w_vel_c;

    // Next-frame position, velocity, state, facing and kick counter.
    always_comb begin
        w_dx       = '0;
        w_facing_n = r_facing;
        if (w_left && !w_right) begin
            w_dx       = -WALK;
            w_facing_n = 1'b1;
        end else if (w_right && !w_left) begin
            w_dx       = WALK;
            w_facing_n = 1'b0;
        end

        // Clamp in 12-bit signed space so neither edge can wrap.
        w_x_sum = $signed({2'b00, r_x}) + w_dx;
        if (w_x_sum < X_LO) begin
            w_x_n = X_LO10;
        end else if (w_x_sum > X_HI) begin
            w_x_n = X_HI10;
        end else begin
            w_x_n = w_x_sum[9:0];
        end

        w_vel_up  = r_vel + GRAV;
        w_vel_c   = (w_vel_up > MAXF) ? MAXF : w_vel_up;
        w_y_sum   = $signed({2'b00, r_y});
        w_y_n     = r_y;
        w_vel_n   = r_vel;
        w_state_n = r_state;

        case (r_state)
            GROUND: begin
                if (w_jump) begin
                    // Launch moves Y on the same frame the jump is taken.
                    w_state_n = AIR;
                    w_vel_n   = -JUMPV;
                    w_y_sum   = $signed({2'b00, r_y}) - JUMPV;
                    if (w_y_sum <= Y_TOP) begin
                        w_y_n   = Y_TOP10;
                        w_vel_n = '0;
                    end else begin
                        w_y_n = w_y_sum[9:0];
                    end
                end else begin
                    w_y_n   = Y_GND10;
                    w_vel_n = '0;
                end
            end
            AIR: begin
                w_y_sum = $signed({2'b00, r_y}) + w_vel_c;
                if (w_y_sum >= Y_GND) begin
                    w_y_n     = Y_GND10;
                    w_vel_n   = '0;
                    w_state_n = GROUND;
                end else if (w_y_sum <= Y_TOP) begin
                    w_y_n   = Y_TOP10;
                    w_vel_n = '0;
                end else begin
                    w_y_n   = w_y_sum[9:0];
                    w_vel_n = w_vel_c;
                end
            end
            default: begin
                w_state_n = AIR;
            end
        endcase

        // Edges arriving while the pulse is running are dropped, not queued.
        if (r_kick_cnt != 8'd0) begin
            w_kick_cnt_n = r_kick_cnt - 8'd1;
        end else if (w_kick && !r_kick_prev) begin
            w_kick_cnt_n = KICK_LOAD;
        end else begin
            w_kick_cnt_n = 8'd0;
        end
    end

    // Frame-rate state register; reset drops the character back at spawn, airborne.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= AIR;
            r_x         <= 10'(SPAWN_X);
            r_y         <= 10'(SPAWN_Y);
            r_vel       <= '0;
            r_facing    <= 1'b0;
            r_kick_cnt  <= 8'd0;
            r_kick_prev <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_x         <= w_x_n;
            r_y         <= w_y_n;
            r_vel       <= w_vel_n;
            r_facing    <= w_facing_n;
            r_kick_cnt  <= w_kick_cnt_n;
            r_kick_prev <= w_kick;
        end
    end

    assign CharX    = r_x;
    assign CharY    = r_y;
    assign CharS    = 10'(SIZE);
    assign Facing   = r_facing;
    assign OnGround = (r_state == GROUND);
    assign Kicking  = (r_kick_cnt != 8'd0);

endmodule

// File: tb/tb_character_ctrl.sv
// tb/tb_character_ctrl.sv - randomized self-checking bench for character_ctrl
module tb_character_ctrl;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [31:0] keycode;
    logic [9:0]  CharX, CharY, CharS;
    logic        Facing, OnGround, Kicking;

    int checks = 0;
    int errors = 0;

    character_ctrl dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .keycode  (keycode),
        .CharX    (CharX),
        .CharY    (CharY),
        .CharS    (CharS),
        .Facing   (Facing),
        .OnGround (OnGround),
        .Kicking  (Kicking)
    );

    always #5 frame_clk = ~frame_clk;

    // Behavioural reference: plain integer physics from the game rules.
    int m_x, m_y, m_vy, m_kcnt;
    bit m_air, m_facing, m_kprev;

    wire [22:0] dut_vec = {CharX, CharY, Facing, OnGround, Kicking};

    function automatic bit has_code(input logic [31:0] kc, input logic [7:0] code);
        for (int i = 0; i < 4; i++) begin
            if (kc[8*i +: 8] == code) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_x = 440; m_y = 240; m_vy = 0; m_air = 1'b1;
        m_facing = 1'b0; m_kcnt = 0; m_kprev = 1'b0;
    endfunction

    function automatic void model_step(input logic [31:0] kc);
        bit l, r, j, k;
        l = has_code(kc, 8'h50); r = has_code(kc, 8'h4F);
        j = has_code(kc, 8'h52); k = has_code(kc, 8'h51);
        if (l && !r) begin m_x -= 4; m_facing = 1'b1; end
        else if (r && !l) begin m_x += 4; m_facing = 1'b0; end
        if (m_x < 0) m_x = 0;
        if (m_x > 607) m_x = 607;
        if (!m_air) begin
            if (j) begin
                m_vy = -18; m_y += m_vy; m_air = 1'b1;
                if (m_y <= 0) begin m_y = 0; m_vy = 0; end
            end else begin
                m_y = 368; m_vy = 0;
            end
        end else begin
            m_vy += 1;
            if (m_vy > 12) m_vy = 12;
            m_y += m_vy;
            if (m_y >= 368) begin m_y = 368; m_vy = 0; m_air = 1'b0; end
            else if (m_y <= 0) begin m_y = 0; m_vy = 0; end
        end
        if (m_kcnt != 0) m_kcnt--;
        else if (k && !m_kprev) m_kcnt = 6;
        m_kprev = k;
    endfunction

    function automatic logic [22:0] model_vec();
        return {10'(m_x), 10'(m_y), m_facing, !m_air, (m_kcnt != 0)};
    endfunction

    function automatic logic [31:0] rand_kc(input int pl, input int pr, input int pj, input int pk);
        logic [7:0] noise [4];
        logic [31:0] kc;
        noise[0] = 8'h00; noise[1] = 8'h04; noise[2] = 8'h1A; noise[3] = 8'h2C;
        for (int i = 0; i < 4; i++) kc[8*i +: 8] = noise[$urandom_range(3)];
        if ($urandom_range(99) < pl) kc[8*$urandom_range(3) +: 8] = 8'h50;
        if ($urandom_range(99) < pr) kc[8*$urandom_range(3) +: 8] = 8'h4F;
        if ($urandom_range(99) < pj) kc[8*$urandom_range(3) +: 8] = 8'h52;
        if ($urandom_range(99) < pk) kc[8*$urandom_range(3) +: 8] = 8'h51;
        return kc;
    endfunction

    task automatic tick(input logic [31:0] kc);
        keycode = kc;
        @(posedge frame_clk);
        #1;
        model_step(kc);
    endtask

    task automatic test_reset();
        Reset = 1'b1; keycode = '0;
        model_reset();
        #12;
        checks++;
        if ({dut_vec, CharS} !== {23'({10'd440, 10'd240, 3'b000}), 10'd32}) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", {dut_vec, CharS}, {23'({10'd440, 10'd240, 3'b000}), 10'd32});
        end
        Reset = 1'b0;
    endtask

    task automatic test_fall();
        for (int f = 0; f < 30; f++) begin
            tick(32'h0);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL fall_track frame=%0d got=%h exp=%h", f, dut_vec, model_vec());
            end
        end
        checks++;
        if ({CharY, OnGround, CharX, Facing} !== {10'd368, 1'b1, 10'd440, 1'b0}) begin
            errors++;
            $display("FAIL fall_settle got y=%0d g=%0d x=%0d f=%0d exp y=368 g=1 x=440 f=0", CharY, OnGround, CharX, Facing);
        end
    endtask

    task automatic test_walk();
        for (int f = 0; f < 10; f++) begin
            tick(32'h0000_0050);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL walk_track frame=%0d got=%h exp=%h", f, dut_vec, model_vec());
            end
        end
        checks++;
        if ({CharX, Facing} !== {10'd400, 1'b1}) begin
            errors++;
            $display("FAIL walk_left got x=%0d f=%0d exp x=400 f=1", CharX, Facing);
        end
        for (int f = 0; f < 5; f++) tick(32'h4F00_0050);
        checks++;
        if ({CharX, Facing} !== {10'd400, 1'b1}) begin
            errors++;
            $display("FAIL walk_both got x=%0d f=%0d exp x=400 f=1", CharX, Facing);
        end
    endtask

    task automatic test_jump();
        int prev_y, min_y, max_drop, n;
        tick(32'h0052_0000);
        checks++;
        if ({CharY, OnGround} !== {10'd350, 1'b0}) begin
            errors++;
            $display("FAIL jump_launch got y=%0d g=%0d exp y=350 g=0", CharY, OnGround);
        end
        prev_y = CharY; min_y = CharY; max_drop = 0; n = 0;
        while (!OnGround && n < 60) begin
            tick(32'h0);
            n++;
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL jump_track frame=%0d got=%h exp=%h", n, dut_vec, model_vec());
            end
            if (int'(CharY) < min_y) min_y = CharY;
            if (int'(CharY) - prev_y > max_drop) max_drop = int'(CharY) - prev_y;
            prev_y = CharY;
        end
        checks++;
        if (!OnGround || CharY !== 10'd368) begin
            errors++;
            $display("FAIL jump_land got y=%0d g=%0d after %0d frames exp y=368 g=1", CharY, OnGround, n);
        end
        checks++;
        if (min_y != 197) begin
            errors++;
            $display("FAIL jump_apex got %0d exp 197", min_y);
        end
        checks++;
        if (max_drop > 12) begin
            errors++;
            $display("FAIL jump_terminal got step %0d exp <= 12", max_drop);
        end
    endtask

    task automatic test_clamp();
        int n;
        n = 0;
        while (CharX != 10'd0 && n < 150) begin
            tick(32'h0000_5000);
            n++;
        end
        for (int f = 0; f < 3; f++) tick(32'h0000_0050);
        checks++;
        if (CharX !== 10'd0 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL clamp_left got x=%0d exp x=0", CharX);
        end
        for (int f = 0; f < 160; f++) begin
            tick(32'h4F00_0000);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL clamp_track frame=%0d got=%h exp=%h", f, dut_vec, model_vec());
            end
        end
        checks++;
        if (CharX !== 10'd607 || Facing !== 1'b0) begin
            errors++;
            $display("FAIL clamp_right got x=%0d f=%0d exp x=607 f=0", CharX, Facing);
        end
    endtask

    task automatic test_kick();
        int high;
        logic [31:0] pattern [3][20];
        for (int s = 0; s < 3; s++)
            for (int f = 0; f < 20; f++) pattern[s][f] = 32'h0;
        pattern[0][0] = 32'h0000_0051;
        pattern[1][0] = 32'h0000_0051;
        pattern[1][3] = 32'h0051_0000;
        for (int f = 0; f < 20; f++) pattern[2][f] = 32'h5100_0000;
        for (int s = 0; s < 3; s++) begin
            high = 0;
            for (int f = 0; f < 20; f++) begin
                tick(pattern[s][f]);
                if (Kicking) high++;
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL kick_track scen=%0d frame=%0d got=%h exp=%h", s, f, dut_vec, model_vec());
                end
            end
            checks++;
            if (high != 6) begin
                errors++;
                $display("FAIL kick_pulse scen=%0d got %0d frames exp 6", s, high);
            end
            tick(32'h0);
        end
    endtask

    task automatic test_random();
        logic [31:0] kc;
        for (int f = 0; f < 400; f++) begin
            kc = rand_kc(40, 40, 15, 15);
            tick(kc);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_track frame=%0d kc=%h got=%h exp=%h", f, kc, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (!OnGround && n < 60) begin
            tick(32'h0);
            n++;
        end
        tick(32'h0000_5152);
        tick(32'h0);
        tick(32'h0);
        checks++;
        if ({OnGround, Kicking} !== 2'b01 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reset_mid_setup got=%h exp=%h", dut_vec, model_vec());
        end
        #2 Reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== model_vec() || dut_vec !== 23'({10'd440, 10'd240, 3'b000})) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", dut_vec, model_vec());
        end
        #2 Reset = 1'b0;
        tick(32'h0);
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reset_mid_resume got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_fall();
        test_walk();
        test_jump();
        test_clamp();
        test_kick();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
